// File: rtl/rule_scheduler_pkg.sv
// Shared types and constants for the guarded-rule scheduler.
// Latency: none (declarations only).
// Backpressure: n/a.
package rule_scheduler_pkg;

   typedef enum logic [1:0] {
      ST_SCAN   = 2'd0,
      ST_OFFER  = 2'd1,
      ST_SETTLE = 2'd2
   } sched_state_t;

   // Low two bits of a rule index select the rule type within a node.
   typedef enum logic [1:0] {
      RULE_TRY  = 2'd0,
      RULE_CRIT = 2'd1,
      RULE_EXIT = 2'd2,
      RULE_IDLE = 2'd3
   } rule_type_t;

   localparam int         IDX_W          = 4;
   localparam logic [3:0] NOP_INDEX      = 4'hF;
   localparam int         RULES_PER_NODE = 4;

   function automatic rule_type_t rule_type_of(input logic [IDX_W-1:0] idx);
      return rule_type_t'(idx[1:0]);
   endfunction

   function automatic logic [1:0] rule_node_of(input logic [IDX_W-1:0] idx);
      return 2'(int'(idx) / RULES_PER_NODE);
   endfunction

endpackage

// File: rtl/rule_scheduler_rr_pick.sv
// Combinational round-robin search: first set guard bit at or after start, with wrap.
// Latency: 0 cycles (pure combinational).
// Backpressure: n/a.
module rr_pick
   import rule_scheduler_pkg::*;
#(
   parameter int N = 12
) (
   input  logic [N-1:0]     guard,
   input  logic [IDX_W-1:0] start,
   output logic             found,
   output logic [IDX_W-1:0] idx
);

   int               cand;
   logic [IDX_W-1:0] cand_idx;

   // Walk offsets from farthest to nearest so the nearest set bit wins.
   always_comb begin
      found    = 1'b0;
      idx      = NOP_INDEX;
      cand     = 0;
      cand_idx = '0;
      for (int off = N - 1; off >= 0; off--) begin
         cand     = (int'(start) + off) % N;
         cand_idx = IDX_W'(cand);
         if (guard[cand_idx]) begin
            found = 1'b1;
            idx   = cand_idx;
         end
      end
   end

endmodule

// File: rtl/rule_scheduler.sv
// Offers one enabled rule at a time, round-robin after the last fired rule; flags deadlock.
// Latency: guard seen in SCAN -> registered offer next cycle; fire-to-fire >= 3 cycles.
// Backpressure: offer held stable (guards ignored) until io_ready; then one SETTLE cycle.
module rule_scheduler
   import rule_scheduler_pkg::*;
#(
   parameter int NUM_RULES      = 12,
   parameter int DEADLOCK_LIMIT = 8
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [NUM_RULES-1:0] io_guard,
   input  logic                 io_ready,
   output logic [3:0]           io_en_a,
   output logic                 io_valid,
   output logic [15:0]          io_fire_count,
   output logic                 io_deadlock
);

   localparam int               CNT_W    = $clog2(DEADLOCK_LIMIT + 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_RULES - 1);
   localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(DEADLOCK_LIMIT);

   sched_state_t     state, state_nxt;
   logic [IDX_W-1:0] ptr, ptr_nxt;
   logic [IDX_W-1:0] search_start;
   logic [3:0]       en_nxt;
   logic             valid_nxt;
   logic [15:0]      fire_nxt;
   logic [CNT_W-1:0] idle_cnt, idle_nxt;
   logic             deadlock_nxt;
   logic             pick_found;
   logic [IDX_W-1:0] pick_idx;

   // Search begins just past the last fired rule, wrapping at the top index.
   assign search_start = (ptr == LAST_IDX) ? '0 : ptr + IDX_W'(1);

   rr_pick #(
      .N (NUM_RULES)
   ) u_pick (
      .guard (io_guard),
      .start (search_start),
      .found (pick_found),
      .idx   (pick_idx)
   );

   // State and all outputs are registered; reset drops any pending offer uncounted.
   always_ff @(posedge clock) begin
      if (reset) begin
         state         <= ST_SCAN;
         ptr           <= LAST_IDX;
         io_en_a       <= NOP_INDEX;
         io_valid      <= 1'b0;
         io_fire_count <= '0;
         idle_cnt      <= '0;
         io_deadlock   <= 1'b0;
      end else begin
         state         <= state_nxt;
         ptr           <= ptr_nxt;
         io_en_a       <= en_nxt;
         io_valid      <= valid_nxt;
         io_fire_count <= fire_nxt;
         idle_cnt      <= idle_nxt;
         io_deadlock   <= deadlock_nxt;
      end
   end

   // Next-state and next-output decode; everything holds unless a state acts on it.
   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      en_nxt    = io_en_a;
      valid_nxt = io_valid;
      fire_nxt  = io_fire_count;
      idle_nxt  = idle_cnt;
      unique case (state)
         ST_SCAN: begin
            if (pick_found) begin
               state_nxt = ST_OFFER;
               en_nxt    = pick_idx;
               valid_nxt = 1'b1;
               idle_nxt  = '0;
            end else begin
               en_nxt    = NOP_INDEX;
               valid_nxt = 1'b0;
               if (idle_cnt != LIMIT) begin
                  idle_nxt = idle_cnt + CNT_W'(1);
               end
            end
         end
         ST_OFFER: begin
            if (io_ready) begin
               state_nxt = ST_SETTLE;
               ptr_nxt   = io_en_a;
               fire_nxt  = io_fire_count + 16'd1;
               en_nxt    = NOP_INDEX;
               valid_nxt = 1'b0;
            end
         end
         ST_SETTLE: begin
            state_nxt = ST_SCAN;
            en_nxt    = NOP_INDEX;
            valid_nxt = 1'b0;
         end
         default: begin
            state_nxt = ST_SCAN;
            en_nxt    = NOP_INDEX;
            valid_nxt = 1'b0;
         end
      endcase
      deadlock_nxt = io_deadlock | (idle_nxt == LIMIT);
   end

endmodule

// File: tb/tb_rule_scheduler.sv
// Self-checking bench for rule_scheduler: scenario tasks with a queue of expected offers.
// Latency: outputs sampled 1ns after each rising edge.
// Backpressure: io_ready driven per scenario.
module tb_rule_scheduler;

   logic        clock = 1'b0;
   logic        reset;
   logic [11:0] io_guard;
   logic        io_ready;
   logic [3:0]  io_en_a;
   logic        io_valid;
   logic [15:0] io_fire_count;
   logic        io_deadlock;

   int          checks = 0;
   int          errors = 0;
   logic [3:0]  exp_q[$];

   always #5 clock = ~clock;

   rule_scheduler #(
      .NUM_RULES      (12),
      .DEADLOCK_LIMIT (8)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .io_guard      (io_guard),
      .io_ready      (io_ready),
      .io_en_a       (io_en_a),
      .io_valid      (io_valid),
      .io_fire_count (io_fire_count),
      .io_deadlock   (io_deadlock)
   );

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Advance until io_valid is seen; cycles = -1 if it never appears within the bound.
   task automatic wait_valid(output int cycles);
      cycles = -1;
      for (int i = 1; i <= 20; i++) begin
         if (cycles < 0) begin
            tick();
            if (io_valid === 1'b1) cycles = i;
         end
      end
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      io_guard = '0;
      io_ready = 1'b0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   // Reference round-robin: first set guard bit strictly after p, wrapping over 12 rules.
   function automatic logic [3:0] model_pick(input int p, input logic [11:0] g);
      logic found;
      int   k;
      found      = 1'b0;
      model_pick = 4'hF;
      for (int off = 1; off <= 12; off++) begin
         k = (p + off) % 12;
         if (!found && g[k]) begin
            found      = 1'b1;
            model_pick = 4'(k);
         end
      end
   endfunction

   task automatic test_reset();
      reset    = 1'b1;
      io_guard = 12'hFFF;
      io_ready = 1'b1;
      tick();
      tick();
      checks++;
      if (io_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", io_valid); end
      checks++;
      if (io_en_a !== 4'hF) begin errors++; $display("FAIL reset_en_a: got %0h expected f", io_en_a); end
      checks++;
      if (io_fire_count !== 16'd0) begin errors++; $display("FAIL reset_fire: got %0d expected 0", io_fire_count); end
      checks++;
      if (io_deadlock !== 1'b0) begin errors++; $display("FAIL reset_deadlock: got %0b expected 0", io_deadlock); end
   endtask

   task automatic test_first_fire();
      logic [3:0] exp;
      reset    = 1'b0;
      io_guard = 12'h001;
      io_ready = 1'b1;
      exp_q.push_back(4'd0);
      tick();
      exp = exp_q.pop_front();
      checks++;
      if (io_valid !== 1'b1 || io_en_a !== exp) begin
         errors++;
         $display("FAIL first_offer: got valid=%0b en_a=%0h expected valid=1 en_a=%0h", io_valid, io_en_a, exp);
      end
      tick();
      io_guard = '0;
      io_ready = 1'b0;
      checks++;
      if (io_fire_count !== 16'd1 || io_valid !== 1'b0) begin
         errors++;
         $display("FAIL first_accept: got fire=%0d valid=%0b expected fire=1 valid=0", io_fire_count, io_valid);
      end
   endtask

   task automatic test_wrap();
      int         n;
      logic [3:0] exp;
      io_guard = 12'h011;
      io_ready = 1'b0;
      exp_q.push_back(4'd4);
      wait_valid(n);
      exp = exp_q.pop_front();
      checks++;
      if (n < 0 || io_en_a !== exp) begin
         errors++;
         $display("FAIL wrap_offer4: got en_a=%0h wait=%0d expected en_a=%0h", io_en_a, n, exp);
      end
      io_ready = 1'b1;
      tick();
      io_ready = 1'b0;
      checks++;
      if (io_fire_count !== 16'd2) begin errors++; $display("FAIL wrap_fire2: got %0d expected 2", io_fire_count); end
      exp_q.push_back(4'd0);
      wait_valid(n);
      exp = exp_q.pop_front();
      checks++;
      if (n < 0 || io_en_a !== exp) begin
         errors++;
         $display("FAIL wrap_offer0: got en_a=%0h wait=%0d expected en_a=%0h", io_en_a, n, exp);
      end
      io_ready = 1'b1;
      tick();
      io_ready = 1'b0;
      io_guard = '0;
      checks++;
      if (io_fire_count !== 16'd3) begin errors++; $display("FAIL wrap_fire3: got %0d expected 3", io_fire_count); end
   endtask

   task automatic test_backpressure();
      int         n;
      logic [3:0] exp;
      io_guard = 12'h100;
      io_ready = 1'b0;
      exp_q.push_back(4'd8);
      wait_valid(n);
      exp = exp_q.pop_front();
      checks++;
      if (n < 0 || io_en_a !== exp) begin
         errors++;
         $display("FAIL bp_offer: got en_a=%0h wait=%0d expected en_a=%0h", io_en_a, n, exp);
      end
      for (int i = 0; i < 5; i++) begin
         io_guard = 12'($urandom);
         tick();
         checks++;
         if (io_en_a !== exp || io_valid !== 1'b1 || io_fire_count !== 16'd3) begin
            errors++;
            $display("FAIL bp_hold[%0d]: got en_a=%0h valid=%0b fire=%0d expected en_a=%0h valid=1 fire=3",
                     i, io_en_a, io_valid, io_fire_count, exp);
         end
      end
      io_ready = 1'b1;
      tick();
      io_ready = 1'b0;
      io_guard = '0;
      checks++;
      if (io_fire_count !== 16'd4 || io_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_accept: got fire=%0d valid=%0b expected fire=4 valid=0", io_fire_count, io_valid);
      end
   endtask

   task automatic test_deadlock();
      int         n;
      logic [3:0] exp;
      do_reset();
      for (int i = 1; i <= 8; i++) begin
         tick();
         checks++;
         if (io_deadlock !== (i == 8)) begin
            errors++;
            $display("FAIL deadlock_cycle%0d: got %0b expected %0b", i, io_deadlock, (i == 8));
         end
      end
      io_guard = 12'h002;
      io_ready = 1'b1;
      exp_q.push_back(4'd1);
      wait_valid(n);
      exp = exp_q.pop_front();
      checks++;
      if (n < 0 || io_en_a !== exp || io_deadlock !== 1'b1) begin
         errors++;
         $display("FAIL deadlock_offer: got en_a=%0h deadlock=%0b wait=%0d expected en_a=%0h deadlock=1",
                  io_en_a, io_deadlock, n, exp);
      end
      tick();
      io_ready = 1'b0;
      io_guard = '0;
      checks++;
      if (io_fire_count !== 16'd1 || io_deadlock !== 1'b1) begin
         errors++;
         $display("FAIL deadlock_held: got fire=%0d deadlock=%0b expected fire=1 deadlock=1",
                  io_fire_count, io_deadlock);
      end
   endtask

   task automatic test_no_deadlock();
      int         n;
      int         bad;
      logic [3:0] exp;
      do_reset();
      bad = 0;
      for (int i = 0; i < 7; i++) begin
         tick();
         if (io_deadlock !== 1'b0) bad++;
      end
      io_guard = 12'h001;
      io_ready = 1'b1;
      exp_q.push_back(4'd0);
      wait_valid(n);
      io_guard = '0;
      exp = exp_q.pop_front();
      checks++;
      if (n < 0 || io_en_a !== exp) begin
         errors++;
         $display("FAIL nodl_offer: got en_a=%0h wait=%0d expected en_a=%0h", io_en_a, n, exp);
      end
      tick();
      io_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (io_deadlock !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL nodl_flag: got %0d cycles with deadlock=1 expected 0", bad); end
   endtask

   task automatic test_reset_in_offer();
      int         n;
      logic [3:0] exp;
      io_guard = 12'h004;
      io_ready = 1'b0;
      exp_q.push_back(4'd2);
      wait_valid(n);
      exp = exp_q.pop_front();
      checks++;
      if (n < 0 || io_en_a !== exp) begin
         errors++;
         $display("FAIL rstoffer_offer: got en_a=%0h wait=%0d expected en_a=%0h", io_en_a, n, exp);
      end
      reset    = 1'b1;
      io_ready = 1'b1;
      tick();
      checks++;
      if (io_valid !== 1'b0 || io_en_a !== 4'hF || io_fire_count !== 16'd0) begin
         errors++;
         $display("FAIL rstoffer_drop: got valid=%0b en_a=%0h fire=%0d expected valid=0 en_a=f fire=0",
                  io_valid, io_en_a, io_fire_count);
      end
      reset    = 1'b0;
      io_ready = 1'b0;
      io_guard = '0;
   endtask

   task automatic test_back_to_back();
      int          n;
      int          model_ptr;
      logic [15:0] exp_fire;
      logic [11:0] g;
      logic [3:0]  exp;
      model_ptr = 11;
      exp_fire  = 16'd0;
      io_ready  = 1'b1;
      for (int t = 0; t < 20; t++) begin
         if (t % 5 == 4)      g = 12'(1) << model_ptr;
         else if (t % 5 == 2) g = 12'h801;
         else                 g = 12'($urandom_range(1, 4095));
         exp_q.push_back(model_pick(model_ptr, g));
         io_guard = g;
         wait_valid(n);
         exp = exp_q.pop_front();
         checks++;
         if (io_en_a !== exp || n != ((t == 0) ? 1 : 2)) begin
            errors++;
            $display("FAIL b2b_offer[%0d]: got en_a=%0h wait=%0d expected en_a=%0h wait=%0d",
                     t, io_en_a, n, exp, (t == 0) ? 1 : 2);
         end
         tick();
         exp_fire  = exp_fire + 16'd1;
         model_ptr = int'(exp);
         checks++;
         if (io_fire_count !== exp_fire || io_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_fire[%0d]: got fire=%0d valid=%0b expected fire=%0d valid=0",
                     t, io_fire_count, io_valid, exp_fire);
         end
      end
      io_ready = 1'b0;
      io_guard = '0;
   endtask

   initial begin
      reset    = 1'b1;
      io_guard = '0;
      io_ready = 1'b0;
      test_reset();
      test_first_fire();
      test_wrap();
      test_backpressure();
      test_deadlock();
      test_no_deadlock();
      test_reset_in_offer();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

endmodule
